// File: rtl/gemm_pkg.sv
// Shared definitions for the gemm instruction scheduler: opcodes, VTA gemm
// instruction field positions and the scheduler state encoding.
package gemm_pkg;

  localparam int unsigned OPC_W = 3;

  localparam logic [OPC_W-1:0] OPC_LOAD   = 3'd0;
  localparam logic [OPC_W-1:0] OPC_STORE  = 3'd1;
  localparam logic [OPC_W-1:0] OPC_GEMM   = 3'd2;
  localparam logic [OPC_W-1:0] OPC_FINISH = 3'd3;
  localparam logic [OPC_W-1:0] OPC_ALU    = 3'd4;

  // Common header
  localparam int unsigned OPC_LSB       = 0;
  localparam int unsigned POP_PREV_BIT  = 3;
  localparam int unsigned POP_NEXT_BIT  = 4;
  localparam int unsigned PUSH_PREV_BIT = 5;
  localparam int unsigned PUSH_NEXT_BIT = 6;

  // Gemm body
  localparam int unsigned RESET_REG_BIT      = 7;
  localparam int unsigned UOP_BGN_LSB        = 8;
  localparam int unsigned UOP_BGN_W          = 13;
  localparam int unsigned UOP_END_LSB        = 21;
  localparam int unsigned UOP_END_W          = 14;
  localparam int unsigned ITER_OUT_LSB       = 35;
  localparam int unsigned ITER_IN_LSB        = 49;
  localparam int unsigned ITER_W             = 14;
  localparam int unsigned DST_FACTOR_OUT_LSB = 63;
  localparam int unsigned DST_FACTOR_IN_LSB  = 74;
  localparam int unsigned SRC_FACTOR_OUT_LSB = 85;
  localparam int unsigned SRC_FACTOR_IN_LSB  = 96;
  localparam int unsigned ACC_FACTOR_W       = 11;
  localparam int unsigned WGT_FACTOR_OUT_LSB = 107;
  localparam int unsigned WGT_FACTOR_IN_LSB  = 117;
  localparam int unsigned WGT_FACTOR_W       = 10;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DEP_WAIT = 3'd1,
    S_START    = 3'd2,
    S_RUN      = 3'd3,
    S_PUSH     = 3'd4
  } sched_state_e;

endpackage

// File: rtl/gemm_dep_token_ctr.sv
// Saturating up/down dependency token counter. Increment and decrement in the
// same cycle cancel; an increment at TOK_MAX holds the count and flags overflow.
module gemm_dep_token_ctr #(
  parameter int unsigned TOK_MAX = 7,
  parameter int unsigned TOK_W   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  output logic [TOK_W-1:0] count,
  output logic             nonzero_c,
  output logic             overflow_c
);

  localparam logic [TOK_W-1:0] CNT_MAX = TOK_W'(TOK_MAX);

  assign nonzero_c  = (count != '0);
  assign overflow_c = inc && !dec && (count == CNT_MAX);

  // Token count update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      unique case ({inc, dec})
        2'b10:   if (count != CNT_MAX) count <= count + TOK_W'(1);
        2'b01:   if (count != '0)      count <= count - TOK_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gemm_insn_sched.sv
// Gemm instruction scheduler: accepts one VTA instruction at a time, waits for
// load/store dependency tokens, launches gemm and returns tokens on completion.
// Optional build macro GEMM_SCHED_PERF_EN adds RUN / DEP_WAIT cycle counters.
module gemm_insn_sched import gemm_pkg::*; #(
  parameter int unsigned       INS_WIDTH  = 128,
  parameter int unsigned       TOK_MAX    = 7,
  parameter int unsigned       TOK_W      = 3,
  parameter logic [OPC_W-1:0]  OPC_GEMM   = 3'd2,
  parameter logic [OPC_W-1:0]  OPC_FINISH = 3'd3
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 insn_valid,
  output logic                 insn_ready,
  input  logic [INS_WIDTH-1:0] insn_data,
  output logic [INS_WIDTH-1:0] gemm_insn,
  output logic                 gemm_start,
  input  logic                 gemm_done,
  input  logic                 l2g_dep,
  input  logic                 s2g_dep,
  output logic                 g2l_dep,
  output logic                 g2s_dep,
  output logic                 busy,
  output logic                 finish,
`ifdef GEMM_SCHED_PERF_EN
  output logic [31:0]          perf_run_cyc,
  output logic [31:0]          perf_stall_cyc,
`endif
  output logic                 err
);

  sched_state_e     state;
  logic [TOK_W-1:0] prev_cnt;
  logic [TOK_W-1:0] next_cnt;
  logic             prev_nz;
  logic             next_nz;
  logic             prev_ovf;
  logic             next_ovf;
  logic             pop_prev;
  logic             pop_next;
  logic             deps_ok;
  logic             dep_go;
  logic             dec_prev;
  logic             dec_next;
  logic [OPC_W-1:0] opcode;

  assign opcode   = gemm_insn[OPC_LSB +: OPC_W];
  assign pop_prev = gemm_insn[POP_PREV_BIT];
  assign pop_next = gemm_insn[POP_NEXT_BIT];
  assign deps_ok  = (!pop_prev || prev_nz) && (!pop_next || next_nz);
  assign dep_go   = (state == S_DEP_WAIT) && deps_ok;
  // Count guard keeps a pop from ever wrapping the counter
  assign dec_prev = dep_go && pop_prev && (prev_cnt != '0);
  assign dec_next = dep_go && pop_next && (next_cnt != '0);

  gemm_dep_token_ctr #(.TOK_MAX(TOK_MAX), .TOK_W(TOK_W)) u_prev_ctr (
    .clk        (ap_clk),
    .rst_n      (ap_rst_n),
    .inc        (l2g_dep),
    .dec        (dec_prev),
    .count      (prev_cnt),
    .nonzero_c  (prev_nz),
    .overflow_c (prev_ovf)
  );

  gemm_dep_token_ctr #(.TOK_MAX(TOK_MAX), .TOK_W(TOK_W)) u_next_ctr (
    .clk        (ap_clk),
    .rst_n      (ap_rst_n),
    .inc        (s2g_dep),
    .dec        (dec_next),
    .count      (next_cnt),
    .nonzero_c  (next_nz),
    .overflow_c (next_ovf)
  );

  // Scheduler FSM with registered outputs
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state      <= S_IDLE;
      insn_ready <= 1'b0;
      gemm_insn  <= '0;
      gemm_start <= 1'b0;
      g2l_dep    <= 1'b0;
      g2s_dep    <= 1'b0;
      busy       <= 1'b0;
      finish     <= 1'b0;
      err        <= 1'b0;
    end else begin
      gemm_start <= 1'b0;
      g2l_dep    <= 1'b0;
      g2s_dep    <= 1'b0;
      if (prev_ovf || next_ovf) err <= 1'b1;
      unique case (state)
        S_IDLE: begin
          if (insn_valid && insn_ready) begin
            gemm_insn  <= insn_data;
            insn_ready <= 1'b0;
            busy       <= 1'b1;
            state      <= S_DEP_WAIT;
          end else begin
            insn_ready <= 1'b1;
            busy       <= 1'b0;
          end
        end
        S_DEP_WAIT: begin
          if (deps_ok) begin
            if (opcode == OPC_GEMM) begin
              gemm_start <= 1'b1;
              state      <= S_START;
            end else begin
              // Non-gemm insns still return their tokens
              if (opcode == OPC_FINISH) finish <= 1'b1;
              else                      err    <= 1'b1;
              g2l_dep <= gemm_insn[PUSH_PREV_BIT];
              g2s_dep <= gemm_insn[PUSH_NEXT_BIT];
              state   <= S_PUSH;
            end
          end
        end
        S_START: begin
          state <= S_RUN;
        end
        S_RUN: begin
          if (gemm_done) begin
            g2l_dep <= gemm_insn[PUSH_PREV_BIT];
            g2s_dep <= gemm_insn[PUSH_NEXT_BIT];
            state   <= S_PUSH;
          end
        end
        S_PUSH: begin
          insn_ready <= 1'b1;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
        default: begin
          insn_ready <= 1'b1;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

`ifdef GEMM_SCHED_PERF_EN
  // Free-running occupancy counters for RUN and DEP_WAIT
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      perf_run_cyc   <= '0;
      perf_stall_cyc <= '0;
    end else begin
      if (state == S_RUN)      perf_run_cyc   <= perf_run_cyc + 32'd1;
      if (state == S_DEP_WAIT) perf_stall_cyc <= perf_stall_cyc + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gemm_insn_sched.sv
// Directed bench for gemm_insn_sched. Cycle n is the interval after the n-th
// rising edge counted from the cycle an instruction is offered.
module tb_gemm_insn_sched;

  logic         ap_clk;
  logic         ap_rst_n;
  logic         insn_valid;
  logic         insn_ready;
  logic [127:0] insn_data;
  logic [127:0] gemm_insn;
  logic         gemm_start;
  logic         gemm_done;
  logic         l2g_dep;
  logic         s2g_dep;
  logic         g2l_dep;
  logic         g2s_dep;
  logic         busy;
  logic         finish;
  logic         err;
`ifdef GEMM_SCHED_PERF_EN
  logic [31:0]  perf_run_cyc;
  logic [31:0]  perf_stall_cyc;
`endif

  int n_cmp = 0;
  int n_mis = 0;
  int n_start = 0;
  int n_g2l = 0;
  int n_g2s = 0;
  int b_start, b_g2l, b_g2s;
  logic [127:0] ins;

  gemm_insn_sched u_dut (
    .ap_clk         (ap_clk),
    .ap_rst_n       (ap_rst_n),
    .insn_valid     (insn_valid),
    .insn_ready     (insn_ready),
    .insn_data      (insn_data),
    .gemm_insn      (gemm_insn),
    .gemm_start     (gemm_start),
    .gemm_done      (gemm_done),
    .l2g_dep        (l2g_dep),
    .s2g_dep        (s2g_dep),
    .g2l_dep        (g2l_dep),
    .g2s_dep        (g2s_dep),
    .busy           (busy),
    .finish         (finish),
`ifdef GEMM_SCHED_PERF_EN
    .perf_run_cyc   (perf_run_cyc),
    .perf_stall_cyc (perf_stall_cyc),
`endif
    .err            (err)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // Pulse tallies sampled at each rising edge
  always @(posedge ap_clk) begin
    if (gemm_start) n_start++;
    if (g2l_dep)    n_g2l++;
    if (g2s_dep)    n_g2s++;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!insn_ready && n < 20) begin
      step();
      n++;
    end
    if (!insn_ready) check("ready_timeout", 128'(insn_ready), 128'd1);
  endtask

  task automatic mark();
    b_start = n_start;
    b_g2l   = n_g2l;
    b_g2s   = n_g2s;
  endtask

  function automatic logic [127:0] mk_insn(input logic [2:0] opc, input logic pp, input logic pn,
                                           input logic hp, input logic hn);
    logic [127:0] v;
    v = 128'h1234_5678_9abc_def0_0fed_cba9_8765_4300;
    v[2:0] = opc;
    v[3] = pp;
    v[4] = pn;
    v[5] = hp;
    v[6] = hn;
    return v;
  endfunction

  initial begin
    ap_rst_n = 1'b0; insn_valid = 1'b0; insn_data = '0;
    gemm_done = 1'b0; l2g_dep = 1'b0; s2g_dep = 1'b0;
    #12;
    check("rst_ready", 128'(insn_ready), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_insn", gemm_insn, 128'd0);
    check("rst_flags", {124'd0, finish, err, g2l_dep, g2s_dep}, 128'd0);
    step();
    ap_rst_n = 1'b1;

    // 1: gemm with no deps, done at cycle 10
    wait_ready(); mark();
    ins = mk_insn(3'd2, 0, 0, 0, 0);
    insn_valid = 1'b1; insn_data = ins;
    step(); insn_valid = 1'b0;
    check("t1_latch", gemm_insn, ins);
    check("t1_c1_ready", 128'(insn_ready), 128'd0);
    check("t1_c1_busy", 128'(busy), 128'd1);
    check("t1_c1_start", 128'(gemm_start), 128'd0);
    step();
    check("t1_c2_start", 128'(gemm_start), 128'd1);
    repeat (8) step();
    gemm_done = 1'b1;
    step(); gemm_done = 1'b0;
    check("t1_c11_ready", 128'(insn_ready), 128'd0);
    step();
    check("t1_c12_ready", 128'(insn_ready), 128'd1);
    check("t1_c12_busy", 128'(busy), 128'd0);
    check("t1_starts", 128'(n_start - b_start), 128'd1);
    check("t1_pushes", 128'((n_g2l - b_g2l) + (n_g2s - b_g2s)), 128'd0);

    // 2: pop_prev, token at cycle 5, start at cycle 7
    wait_ready(); mark();
    insn_valid = 1'b1; insn_data = mk_insn(3'd2, 1, 0, 0, 0);
    step(); insn_valid = 1'b0;
    repeat (4) step();
    l2g_dep = 1'b1;
    step(); l2g_dep = 1'b0;
    check("t2_c6_start", 128'(gemm_start), 128'd0);
    check("t2_c6_cnt", 128'(u_dut.u_prev_ctr.count), 128'd1);
    step();
    check("t2_c7_start", 128'(gemm_start), 128'd1);
    check("t2_c7_cnt", 128'(u_dut.u_prev_ctr.count), 128'd0);
    check("t2_starts", 128'(n_start - b_start), 128'd0);
    step(); gemm_done = 1'b1;
    step(); gemm_done = 1'b0;
    step();

    // 3: push both, pulses the cycle after done
    wait_ready(); mark();
    insn_valid = 1'b1; insn_data = mk_insn(3'd2, 0, 0, 1, 1);
    step(); insn_valid = 1'b0;
    step();
    check("t3_c2_start", 128'(gemm_start), 128'd1);
    step(); gemm_done = 1'b1;
    step(); gemm_done = 1'b0;
    check("t3_c4_push", {126'd0, g2l_dep, g2s_dep}, 128'd3);
    step();
    check("t3_c5_push", {126'd0, g2l_dep, g2s_dep}, 128'd0);
    check("t3_c5_ready", 128'(insn_ready), 128'd1);
    check("t3_g2l_cnt", 128'(n_g2l - b_g2l), 128'd1);
    check("t3_g2s_cnt", 128'(n_g2s - b_g2s), 128'd1);

    // 4: saturation at 7 sets err on the 8th token
    l2g_dep = 1'b1;
    repeat (7) step();
    check("t4_cnt7", 128'(u_dut.u_prev_ctr.count), 128'd7);
    check("t4_err_pre", 128'(err), 128'd0);
    step(); l2g_dep = 1'b0;
    check("t4_cnt_sat", 128'(u_dut.u_prev_ctr.count), 128'd7);
    check("t4_err", 128'(err), 128'd1);
    ap_rst_n = 1'b0;
    step();
    check("t4_rst_err", 128'(err), 128'd0);
    check("t4_rst_cnt", 128'(u_dut.u_prev_ctr.count), 128'd0);
    ap_rst_n = 1'b1;
    l2g_dep = 1'b1;
    repeat (3) step();
    l2g_dep = 1'b0;
    check("t4_cnt3", 128'(u_dut.u_prev_ctr.count), 128'd3);
    wait_ready();
    insn_valid = 1'b1; insn_data = mk_insn(3'd2, 1, 0, 0, 0);
    step(); insn_valid = 1'b0; l2g_dep = 1'b1;
    step(); l2g_dep = 1'b0;
    check("t4_coinc_cnt", 128'(u_dut.u_prev_ctr.count), 128'd3);
    check("t4_coinc_start", 128'(gemm_start), 128'd1);
    step(); gemm_done = 1'b1;
    step(); gemm_done = 1'b0;
    step();

    // 5: FINISH then an illegal opcode
    wait_ready(); mark();
    insn_valid = 1'b1; insn_data = mk_insn(3'd3, 0, 0, 0, 0);
    step(); insn_valid = 1'b0;
    step();
    check("t5_finish", 128'(finish), 128'd1);
    check("t5_err", 128'(err), 128'd0);
    step();
    check("t5_ready", 128'(insn_ready), 128'd1);
    insn_valid = 1'b1; insn_data = mk_insn(3'd6, 0, 0, 1, 1);
    step(); insn_valid = 1'b0;
    step();
    check("t5_bad_err", 128'(err), 128'd1);
    check("t5_bad_push", {126'd0, g2l_dep, g2s_dep}, 128'd3);
    check("t5_finish_hold", 128'(finish), 128'd1);
    step();
    check("t5_bad_ready", 128'(insn_ready), 128'd1);
    check("t5_starts", 128'(n_start - b_start), 128'd0);

    // 6: async reset while in RUN
    wait_ready(); mark();
    insn_valid = 1'b1; insn_data = mk_insn(3'd2, 0, 0, 1, 1);
    step(); insn_valid = 1'b0;
    step(); step(); step();
    check("t6_busy_run", 128'(busy), 128'd1);
    #2 ap_rst_n = 1'b0;
    #1;
    check("t6_rst_outs", {121'd0, insn_ready, busy, gemm_start, g2l_dep, g2s_dep, finish, err}, 128'd0);
    check("t6_rst_insn", gemm_insn, 128'd0);
    step();
    ap_rst_n = 1'b1;
    step();
    gemm_done = 1'b1;
    step(); gemm_done = 1'b0;
    step();
    check("t6_late_done_push", 128'((n_g2l - b_g2l) + (n_g2s - b_g2s)), 128'd0);
    check("t6_idle_busy", 128'(busy), 128'd0);
    wait_ready(); mark();
    insn_valid = 1'b1; insn_data = mk_insn(3'd2, 0, 0, 1, 0);
    step(); insn_valid = 1'b0;
    step();
    check("t6_restart", 128'(gemm_start), 128'd1);
    step(); gemm_done = 1'b1;
    step(); gemm_done = 1'b0;
    check("t6_push", {126'd0, g2l_dep, g2s_dep}, 128'd2);
    step();
    check("t6_ready", 128'(insn_ready), 128'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
